// File: rtl/pcre_chain_engine.sv
// Linear character-class chain matcher with per-step quantifiers (ONE/PLUS/STAR/OPT).
// Tracks per-step consumption state and reports first-match offset, completion pulses and count.
module pcre_chain_engine #(
    parameter int unsigned N_STEPS  = 16,
    parameter int unsigned N_CLASS  = 24,
    parameter int unsigned CLS_W    = 5,
    parameter int unsigned OFS_W    = 16,
    parameter int unsigned ANCHORED = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       sod,
    input  logic                       en,
    input  logic [N_CLASS-1:0]         cls_hit,
    input  logic [5:0]                 cfg_len,
    input  logic [N_STEPS*CLS_W-1:0]   cfg_class,
    input  logic [N_STEPS*2-1:0]       cfg_mode,
    output logic                       match,
    output logic                       match_pls,
    output logic [OFS_W-1:0]           match_ofs,
    output logic [OFS_W-1:0]           match_cnt
);

    typedef enum logic [1:0] {
        MODE_ONE  = 2'd0,
        MODE_PLUS = 2'd1,
        MODE_STAR = 2'd2,
        MODE_OPT  = 2'd3
    } mode_e;

    localparam int unsigned HIT_W = 2 ** CLS_W;

    logic [N_STEPS-1:0] s_q, s_d;
    logic [OFS_W-1:0]   ofs_q, ofs_d;
    logic [OFS_W-1:0]   mofs_q, mofs_d;
    logic [OFS_W-1:0]   cnt_q, cnt_d;
    logic               match_q, match_d;
    logic               pls_q, pls_d;

    logic [HIT_W-1:0]   hit_pad;
    logic [N_STEPS-1:0] hit, skip, loop, live, reach, next_s, prior_s;
    logic [OFS_W-1:0]   prior_ofs, prior_mofs, prior_cnt;
    logic               prior_match, len_ok, start, done, byte_done;
    logic               r_acc, tail_ok;

    // Indices at or above N_CLASS land in the zero-extended padding and never hit.
    assign hit_pad = HIT_W'(cls_hit);
    assign len_ok  = (cfg_len != 6'd0) && (32'(cfg_len) <= N_STEPS);

    for (genvar g = 0; g < int'(N_STEPS); g++) begin : g_step
        mode_e            step_mode;
        logic [CLS_W-1:0] step_cls;
        assign step_mode = mode_e'(cfg_mode[2*g +: 2]);
        assign step_cls  = cfg_class[g*CLS_W +: CLS_W];
        assign hit[g]    = hit_pad[step_cls];
        assign skip[g]   = (step_mode == MODE_STAR) || (step_mode == MODE_OPT);
        assign loop[g]   = (step_mode == MODE_PLUS) || (step_mode == MODE_STAR);
        assign live[g]   = (g < int'(cfg_len));
    end

    always_comb begin
        prior_s     = sod ? '0 : s_q;
        prior_ofs   = sod ? '0 : ofs_q;
        prior_mofs  = sod ? '0 : mofs_q;
        prior_cnt   = sod ? '0 : cnt_q;
        prior_match = sod ? 1'b0 : match_q;

        start = (ANCHORED != 0) ? (prior_ofs == '0) : 1'b1;

        reach = '0;
        r_acc = start;
        for (int unsigned i = 0; i < N_STEPS; i++) begin
            reach[i] = r_acc;
            r_acc    = prior_s[i] | (skip[i] & r_acc);
        end

        next_s = live & hit & (reach | (loop & prior_s));

        // Walk back from the last live step: completion may end on any step whose
        // successors are all optional; the start term is excluded so >=1 byte is consumed.
        done    = 1'b0;
        tail_ok = 1'b1;
        for (int unsigned k = 0; k < N_STEPS; k++) begin
            if (live[N_STEPS-1-k]) begin
                done    = done | (tail_ok & next_s[N_STEPS-1-k]);
                tail_ok = tail_ok & skip[N_STEPS-1-k];
            end
        end
        done      = done & len_ok;
        byte_done = en & done;

        s_d     = en ? next_s : prior_s;
        ofs_d   = (en && (prior_ofs != '1)) ? prior_ofs + 1'b1 : prior_ofs;
        match_d = prior_match | byte_done;
        mofs_d  = (byte_done && !prior_match) ? prior_ofs : prior_mofs;
        cnt_d   = (byte_done && (prior_cnt != '1)) ? prior_cnt + 1'b1 : prior_cnt;
        pls_d   = byte_done;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_q     <= '0;
            ofs_q   <= '0;
            mofs_q  <= '0;
            cnt_q   <= '0;
            match_q <= 1'b0;
            pls_q   <= 1'b0;
        end else begin
            s_q     <= s_d;
            ofs_q   <= ofs_d;
            mofs_q  <= mofs_d;
            cnt_q   <= cnt_d;
            match_q <= match_d;
            pls_q   <= pls_d;
        end
    end

    assign match     = match_q;
    assign match_pls = pls_q;
    assign match_ofs = mofs_q;
    assign match_cnt = cnt_q;

endmodule
